serial_adder_sched: RTL and testbench
=====================================

# serial_adder_sched

Scheduler that shares one bit-serial adder datapath between `NREQ` requesters. It picks requests round-robin and loads the operands. It then drives the datapath's reset/load/enable controls for `WIDTH` shift cycles, collects the serial sum bits into a parallel result, and returns the result to the winning requester over a valid/ready response channel. It sits between the requester ports and the serial adder datapath and replaces the standalone reset/load/shift FSM as the datapath's sequencer.

## Interface
- `WIDTH`, 8, operand/result width; also the number of shift cycles.
- `NREQ`, 2, number of requesters, ≥2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `resetn_i`  in  1  reset, asynchronous assert, active-low.
- `req_valid_i`  in  NREQ  request pending, one bit per requester.
- `req_a_i`, `req_b_i`  in  NREQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready_o`  out  NREQ  one-hot accept; a transfer happens when valid and ready are both high.
- `dp_reset_o`  out  1  holds the datapath (shift regs, carry flop) cleared.
- `dp_load_o`  out  1  datapath parallel-loads `dp_a_o`/`dp_b_o` and clears carry.
- `dp_enable_o`  out  1  datapath shifts one bit (LSB first) and updates carry.
- `dp_a_o`, `dp_b_o`  out  WIDTH  registered operands of the accepted request.
- `dp_sum_bit_i`  in  1  datapath sum bit for the current LSBs (combinational).
- `dp_cout_i`  in  1  datapath full-adder carry-out for the current bit (combinational).
- `rsp_valid_o`  out  1  result available.
- `rsp_ready_i`  in  1  consumer accepts the result.
- `rsp_id_o`  out  max(1,$clog2(NREQ))  index of the requester that owns the result.
- `rsp_sum_o`  out  WIDTH  sum.
- `rsp_cout_o`  out  1  unsigned carry-out.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- States, defined in the package: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `dp_reset_o`=1.
  - If any `req_valid_i` is set, the arbiter grants index g.
  - `req_ready_o[g]`=1, combinational in IDLE only.
  - On the clock edge: latch operands into `dp_a_o`/`dp_b_o`, latch g into `rsp_id_o`, set the rr pointer to g+1 mod NREQ, go to LOAD.
- LOAD, 1 cycle: `dp_load_o`=1, bit counter cleared, next state SHIFT.
- SHIFT, exactly WIDTH cycles: `dp_enable_o`=1. Each edge:
  - `rsp_sum_o[cnt]` ← `dp_sum_bit_i`.
  - Counter increments.
  - On the edge where cnt==WIDTH-1: `rsp_cout_o` ← `dp_cout_i`, go to DONE.
- DONE: `rsp_valid_o`=1, held stable until `rsp_ready_i`. On the handshake edge go to IDLE.
- Round-robin arbitration: search starts at the pointer and takes the first set valid bit. The pointer moves only on a grant.
- Requests arriving in states other than IDLE see ready=0 and wait; no queueing.
- Counter width is $clog2(WIDTH+1).
- The sum wraps modulo 2^WIDTH; the carry is reported only on `rsp_cout_o`.
- Only one of `dp_reset_o`/`dp_load_o`/`dp_enable_o` is high in any cycle.

## Timing
- Reset values (asynchronous, immediate): state IDLE, rr pointer 0, counter 0, `dp_a_o`/`dp_b_o`/`rsp_*` 0, `req_ready_o` 0.
  - `dp_reset_o` is 1 during reset because the state is IDLE.
- Latency: accept edge at T. LOAD runs in T+1. SHIFT runs T+2 … T+WIDTH+1. `rsp_valid_o` rises in cycle T+WIDTH+2.
- Minimum back-to-back: with `rsp_ready_i`=1 throughout, the next accept comes one cycle after DONE. Period is WIDTH+3 cycles.
- Stall: `rsp_ready_i`=0 holds DONE indefinitely; `busy_o` stays 1.
- Reset mid-operation: the in-flight job is dropped and produces no response. The requester already saw its handshake and must resubmit.
- Simultaneous valid on all requesters out of reset: index 0 wins first.

## Configuration
- `SERIAL_SCHED_OVF_EN` defined:
  - Adds output `rsp_ovf_o` (1 bit), the two's-complement signed overflow, captured on the last SHIFT edge: (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
  - Reset value 0.
- Undefined: the port and its logic are absent.

## Structure
- Package `serial_adder_pkg`:
  - `sched_state_t` (logic [1:0], IDLE=0, LOAD=1, SHIFT=2, DONE=3).
  - Default `WIDTH`=8.
  - The existing datapath state enum moves here.
- Sub-module `rr_arbiter` (params `NREQ`; ports: requests, pointer, one-hot grant, grant index), purely combinational.
- The pointer register stays in `serial_adder_sched`.

## Test plan
The bench drives `dp_*` inputs from a behavioral serial adder (LSB shift regs plus carry flop).
- Req0 a=0x3C, b=0x05 → `rsp_sum_o`=0x41, `rsp_cout_o`=0, `rsp_id_o`=0, valid at exactly accept+10 cycles (WIDTH=8).
- Req1 a=0xFF, b=0x01 → sum 0x00, cout 1, id 1. With the macro: 0x7F+0x01 → ovf 1; 0xFF+0x01 → ovf 0.
- Both valid continuously, 4 jobs → grant order 0,1,0,1; one-hot `req_ready_o` seen only in IDLE.
- `rsp_ready_i` held low 5 cycles in DONE → `rsp_valid_o`/sum/id stable, no new grant, then IDLE one cycle after release.
- `resetn_i` low for 1 cycle during SHIFT cycle 3 → outputs reach reset values immediately, no `rsp_valid_o`, next request completes correctly.
- Control exclusivity assertion over all tests: at most one of `dp_reset_o`/`dp_load_o`/`dp_enable_o` high; `dp_enable_o` high exactly 8 cycles per job.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types for the serial adder scheduler and its datapath.
// State encodings, default width and an index-width helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        DP_CLEAR = 2'd0,
        DP_LOAD  = 2'd1,
        DP_SHIFT = 2'd2
    } dp_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i.
// Produces a one-hot grant and the matching binary index.
module rr_arbiter
    import serial_adder_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o
);

    logic found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(ptr_i) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/serial_adder_sched.sv
// Round-robin sequencer sharing one bit-serial adder among NREQ requesters.
// Define SERIAL_SCHED_OVF_EN to add the signed-overflow output rsp_ovf_o.
module serial_adder_sched
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREQ  = 2,
    parameter int IDW   = idx_w(NREQ)
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic                  dp_reset_o,
    output logic                  dp_load_o,
    output logic                  dp_enable_o,
    output logic [WIDTH-1:0]      dp_a_o,
    output logic [WIDTH-1:0]      dp_b_o,
    input  logic                  dp_sum_bit_i,
    input  logic                  dp_cout_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [IDW-1:0]        rsp_id_o,
    output logic [WIDTH-1:0]      rsp_sum_o,
    output logic                  rsp_cout_o,
    output logic                  busy_o
`ifdef SERIAL_SCHED_OVF_EN
    ,
    output logic                  rsp_ovf_o
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    sched_state_t   state_q, state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [CW-1:0]  cnt_q;
    logic           accept;
    logic           last_bit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign accept   = (state_q == IDLE) && (|req_valid_i);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign busy_o   = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        dp_reset_o  = 1'b0;
        dp_load_o   = 1'b0;
        dp_enable_o = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                dp_reset_o = 1'b1;
                // ready stays low while reset is held
                if (resetn_i) req_ready_o = gnt;
                if (accept) state_d = LOAD;
            end
            LOAD: begin
                dp_load_o = 1'b1;
                state_d   = SHIFT;
            end
            SHIFT: begin
                dp_enable_o = 1'b1;
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            dp_a_o     <= '0;
            dp_b_o     <= '0;
            rsp_id_o   <= '0;
            rsp_sum_o  <= '0;
            rsp_cout_o <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        dp_a_o   <= req_a_i[gnt_idx*WIDTH +: WIDTH];
                        dp_b_o   <= req_b_i[gnt_idx*WIDTH +: WIDTH];
                        rsp_id_o <= gnt_idx;
                        if (gnt_idx == IDW'(NREQ - 1)) ptr_q <= '0;
                        else                           ptr_q <= gnt_idx + 1'b1;
                    end
                end
                LOAD: cnt_q <= '0;
                SHIFT: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (cnt_q == CW'(i)) rsp_sum_o[i] <= dp_sum_bit_i;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) rsp_cout_o <= dp_cout_i;
                end
                DONE: ;
            endcase
        end
    end

`ifdef SERIAL_SCHED_OVF_EN
    // The MSB sum bit is still on dp_sum_bit_i at the final shift edge.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rsp_ovf_o <= 1'b0;
        end else if (state_q == SHIFT && last_bit) begin
            rsp_ovf_o <= (dp_a_o[WIDTH-1] == dp_b_o[WIDTH-1]) &&
                         (dp_sum_bit_i != dp_a_o[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder_sched.sv
// Scoreboard bench for serial_adder_sched with a behavioral serial adder.
// Build with SERIAL_SCHED_OVF_EN defined to also check rsp_ovf_o.
module tb_serial_adder_sched;

    localparam int W = 8;

    typedef struct packed {
        logic [0:0]   id;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [1:0]     req_valid = '0;
    logic [2*W-1:0] req_a = '0;
    logic [2*W-1:0] req_b = '0;
    logic [1:0]     req_ready_o;
    logic           dp_reset_o, dp_load_o, dp_enable_o;
    logic [W-1:0]   dp_a_o, dp_b_o;
    logic           dp_sum_bit, dp_cout;
    logic           rsp_valid_o;
    logic           rsp_ready = 1'b1;
    logic [0:0]     rsp_id_o;
    logic [W-1:0]   rsp_sum_o;
    logic           rsp_cout_o;
    logic           busy_o;
`ifdef SERIAL_SCHED_OVF_EN
    logic           rsp_ovf_o;
`endif

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int en_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    serial_adder_sched #(.WIDTH(W), .NREQ(2)) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .req_valid_i  (req_valid),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_ready_o  (req_ready_o),
        .dp_reset_o   (dp_reset_o),
        .dp_load_o    (dp_load_o),
        .dp_enable_o  (dp_enable_o),
        .dp_a_o       (dp_a_o),
        .dp_b_o       (dp_b_o),
        .dp_sum_bit_i (dp_sum_bit),
        .dp_cout_i    (dp_cout),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id_o),
        .rsp_sum_o    (rsp_sum_o),
        .rsp_cout_o   (rsp_cout_o),
        .busy_o       (busy_o)
`ifdef SERIAL_SCHED_OVF_EN
        ,
        .rsp_ovf_o    (rsp_ovf_o)
`endif
    );

    // behavioral serial adder datapath
    logic [W-1:0] ma, mb;
    logic         mc;
    assign dp_sum_bit = ma[0] ^ mb[0] ^ mc;
    assign dp_cout = (ma[0] & mb[0]) | (mc & (ma[0] ^ mb[0]));

    always @(posedge clk) begin
        if (dp_reset_o) begin
            ma <= '0; mb <= '0; mc <= 1'b0;
        end else if (dp_load_o) begin
            ma <= dp_a_o; mb <= dp_b_o; mc <= 1'b0;
        end else if (dp_enable_o) begin
            ma <= ma >> 1; mb <= mb >> 1; mc <= dp_cout;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dp_load_o) en_cnt <= 0;
        else if (dp_enable_o) en_cnt <= en_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int id, input int sum,
                                input int cout, input int ovf);
        exp_t e;
        e.id = 1'(id); e.sum = W'(sum);
        e.cout = 1'(cout); e.ovf = 1'(ovf);
        return e;
    endfunction

    // monitor: pop and compare on every response handshake
    always @(negedge clk) begin
        exp_t e;
        if (resetn && rsp_valid_o && rsp_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_rsp: id %0d sum 0x%0h, none expected",
                         rsp_id_o, rsp_sum_o);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id_o), 32'(e.id));
                chk("rsp_sum", 32'(rsp_sum_o), 32'(e.sum));
                chk("rsp_cout", 32'(rsp_cout_o), 32'(e.cout));
                chk("enable_cycles", 32'(en_cnt), 32'(W));
`ifdef SERIAL_SCHED_OVF_EN
                chk("rsp_ovf", 32'(rsp_ovf_o), 32'(e.ovf));
`endif
            end
        end
    end

    // control exclusivity and ready-only-in-IDLE over the whole run
    always @(negedge clk) begin
        a_excl: assert ($onehot0({dp_reset_o, dp_load_o, dp_enable_o}))
        else begin
            mismatched++;
            $display("FAIL ctl_excl: reset %b load %b enable %b",
                     dp_reset_o, dp_load_o, dp_enable_o);
        end
        if (!$onehot0(req_ready_o) || (busy_o && req_ready_o != 2'b00)) begin
            mismatched++;
            $display("FAIL ready_idle: ready %b busy %b", req_ready_o, busy_o);
        end
    end

    task automatic issue(input int id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic push,
                         input exp_t e, output int c0);
        bit ok = 0;
        if (push) exp_q.push_back(e);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id] = 1'b1;
        c0 = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (req_ready_o[id]) begin ok = 1; c0 = cyc; end
        end
        chk("accept_seen", 32'(ok), 32'd1);
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic wait_valid(output int c1);
        bit ok = 0;
        c1 = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (rsp_valid_o) begin ok = 1; c1 = cyc; end
        end
        chk("valid_seen", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy_o) ok = 1;
        end
        chk("drained", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int c0, c1, accepts;
        bit ok;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_dp_reset", 32'(dp_reset_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_dp_a", 32'(dp_a_o), 32'd0);
        chk("rst_sum", 32'(rsp_sum_o), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;

        // latency and basic add on requester 0
        issue(0, 8'h3C, 8'h05, 1'b1, mk(0, 8'h41, 0, 0), c0);
        wait_valid(c1);
        chk("latency", 32'(c1 - c0), 32'd10);
        drain();

        issue(1, 8'hFF, 8'h01, 1'b1, mk(1, 8'h00, 1, 0), c0);
        drain();
        issue(0, 8'h7F, 8'h01, 1'b1, mk(0, 8'h80, 0, 1), c0);
        drain();

        // stall in DONE with requester 0 waiting
        rsp_ready = 1'b0;
        issue(1, 8'h80, 8'h80, 1'b1, mk(1, 8'h00, 1, 1), c0);
        wait_valid(c1);
        exp_q.push_back(mk(0, 8'h33, 0, 0));
        req_a[0 +: W] = 8'h11;
        req_b[0 +: W] = 8'h22;
        req_valid[0] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            chk("stall_valid", 32'(rsp_valid_o), 32'd1);
            chk("stall_sum", 32'(rsp_sum_o), 32'h00);
            chk("stall_id", 32'(rsp_id_o), 32'd1);
            chk("stall_ready", 32'(req_ready_o), 32'd0);
            chk("stall_busy", 32'(busy_o), 32'd1);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_idle", 32'(busy_o), 32'd0);
        chk("release_grant", 32'(req_ready_o), 32'b01);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        drain();

        // reset during the third SHIFT cycle drops the job
        issue(0, 8'h12, 8'h34, 1'b0, mk(0, 0, 0, 0), c0);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_dp_reset", 32'(dp_reset_o), 32'd1);
        chk("midrst_enable", 32'(dp_enable_o), 32'd0);
        chk("midrst_dp_a", 32'(dp_a_o), 32'd0);
        chk("midrst_sum", 32'(rsp_sum_o), 32'd0);
        chk("midrst_valid", 32'(rsp_valid_o), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        ok = 1;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (rsp_valid_o) ok = 0;
        end
        chk("midrst_no_rsp", 32'(ok), 32'd1);
        @(posedge clk); #1;
        issue(1, 8'hA5, 8'h5A, 1'b1, mk(1, 8'hFF, 0, 0), c0);
        drain();

        // both requesters valid: strict alternation starting at 0
        exp_q.push_back(mk(0, 8'h03, 0, 0));
        exp_q.push_back(mk(1, 8'h10, 1, 0));
        exp_q.push_back(mk(0, 8'h03, 0, 0));
        exp_q.push_back(mk(1, 8'h10, 1, 0));
        req_a = {8'hF0, 8'h01};
        req_b = {8'h20, 8'h02};
        req_valid = 2'b11;
        accepts = 0;
        for (int n = 0; n < 200 && accepts < 4; n++) begin
            @(negedge clk);
            if (|(req_valid & req_ready_o)) accepts++;
        end
        chk("rr_accepts", 32'(accepts), 32'd4);
        @(posedge clk); #1 req_valid = 2'b00;
        drain();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
